// File: rtl/t07_button_conditioner.sv
// Button conditioner: per-button 2-flop synchronizer, debounce FSM with
// counter, and hold-to-repeat timer. All outputs come straight from flops.
module t07_button_conditioner #(
  parameter int unsigned N_BTN         = 6,
  parameter int unsigned DB_LIMIT      = 50000,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [N_BTN-1:0] button_raw,
  output logic [N_BTN-1:0] button_level,
  output logic [N_BTN-1:0] button_press,
  output logic [N_BTN-1:0] button_release,
  output logic [N_BTN-1:0] button_repeat,
  output logic             any_press
);

  localparam int unsigned DbW    = $clog2(DB_LIMIT + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam bit          RepEnable = (REPEAT_DELAY != 0);

  // Counter value that means "this disagreeing cycle is the DB_LIMIT-th one"
  localparam logic [DbW-1:0]  DbLast     = DbW'(DB_LIMIT - 1);
  // Timer counts down to zero; loading N-1 makes expiry land N edges later
  localparam logic [RepW-1:0] DelayLoad  = RepW'(RepEnable ? REPEAT_DELAY - 1 : 0);
  localparam logic [RepW-1:0] PeriodLoad = RepW'(REPEAT_PERIOD - 1);

  // Bit 1 of the encoding is the debounced level
  typedef enum logic [1:0] {
    StIdle           = 2'b00,
    StConfirmPress   = 2'b01,
    StHeld           = 2'b10,
    StConfirmRelease = 2'b11
  } state_e;

  state_e            state_q  [N_BTN];
  state_e            state_d  [N_BTN];
  logic [DbW-1:0]    db_cnt_q [N_BTN];
  logic [DbW-1:0]    db_cnt_d [N_BTN];
  logic [RepW-1:0]   rep_q    [N_BTN];
  logic [RepW-1:0]   rep_d    [N_BTN];

  logic [N_BTN-1:0]  sync1_q, sync2_q;
  logic [N_BTN-1:0]  level;
  logic [N_BTN-1:0]  press_q, press_d;
  logic [N_BTN-1:0]  release_q, release_d;
  logic [N_BTN-1:0]  repeat_q, repeat_d;
  logic              any_q, any_d;

  // Synchronizers sample continuously, independent of en
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounced level decoded from the state register
  always_comb begin
    level = '0;
    for (int i = 0; i < N_BTN; i++) begin
      level[i] = (state_q[i] == StHeld) || (state_q[i] == StConfirmRelease);
    end
  end

  // Next-state: debounce FSM, edge pulses and repeat timer per button
  always_comb begin
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]  = state_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      rep_d[i]    = rep_q[i];

      unique case (state_q[i])
        StIdle, StConfirmPress: begin
          if (sync2_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
              state_d[i]  = StHeld;
              db_cnt_d[i] = '0;
              press_d[i]  = 1'b1;
            end else begin
              state_d[i]  = StConfirmPress;
              db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
          end else begin
            state_d[i]  = StIdle;
            db_cnt_d[i] = '0;
          end
        end
        StHeld, StConfirmRelease: begin
          if (!sync2_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
              state_d[i]   = StIdle;
              db_cnt_d[i]  = '0;
              release_d[i] = 1'b1;
            end else begin
              state_d[i]  = StConfirmRelease;
              db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
          end else begin
            state_d[i]  = StHeld;
            db_cnt_d[i] = '0;
          end
        end
        default: begin
          state_d[i]  = StIdle;
          db_cnt_d[i] = '0;
        end
      endcase

      // A release on the expiry edge wins; the repeat is dropped
      if (press_d[i]) begin
        rep_d[i] = DelayLoad;
      end else if (release_d[i] || !level[i]) begin
        rep_d[i] = '0;
      end else if (RepEnable) begin
        if (rep_q[i] == '0) begin
          repeat_d[i] = 1'b1;
          rep_d[i]    = PeriodLoad;
        end else begin
          rep_d[i] = rep_q[i] - RepW'(1);
        end
      end

      if (!en) begin
        state_d[i]  = StIdle;
        db_cnt_d[i] = '0;
        rep_d[i]    = '0;
      end
    end

    if (!en) begin
      press_d   = '0;
      release_d = '0;
      repeat_d  = '0;
    end
    any_d = |(press_d | repeat_d);
  end

  // State, counters and registered pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= StIdle;
        db_cnt_q[i] <= '0;
        rep_q[i]    <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= state_d[i];
        db_cnt_q[i] <= db_cnt_d[i];
        rep_q[i]    <= rep_d[i];
      end
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= any_d;
    end
  end

  assign button_level   = level;
  assign button_press   = press_q;
  assign button_release = release_q;
  assign button_repeat  = repeat_q;
  assign any_press      = any_q;

endmodule

// File: tb/tb_t07_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulse events, monitors pop and
// compare whenever a DUT shows any pulse. Second instance has repeat disabled.
module tb_t07_button_conditioner;

  typedef struct {
    int         cyc;
    logic [5:0] press;
    logic [5:0] rel;
    logic [5:0] rep;
    logic       any;
  } ev_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       en;
  logic [5:0] raw, raw_nr;
  logic [5:0] level, press, rel, rep;
  logic [5:0] level_nr, press_nr, rel_nr, rep_nr;
  logic       anyp, anyp_nr;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m;
  ev_t exp_q[$];
  ev_t exp_nr_q[$];
  ev_t mon_e, mon_nr_e;

  t07_button_conditioner #(
    .N_BTN(6), .DB_LIMIT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .button_raw(raw),
    .button_level(level), .button_press(press), .button_release(rel),
    .button_repeat(rep), .any_press(anyp)
  );

  t07_button_conditioner #(
    .N_BTN(6), .DB_LIMIT(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
  ) dut_nr (
    .clk(clk), .nrst(nrst), .en(en), .button_raw(raw_nr),
    .button_level(level_nr), .button_press(press_nr), .button_release(rel_nr),
    .button_repeat(rep_nr), .any_press(anyp_nr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the repeating instance
  always @(negedge clk) begin
    if (nrst && ((|press) || (|rel) || (|rep) || anyp)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL mon: unexpected event cyc=%0d press=%b rel=%b rep=%b any=%b, none required",
                 cyc, press, rel, rep, anyp);
      end else begin
        mon_e = exp_q.pop_front();
        if ({cyc, press, rel, rep, anyp} !== {mon_e.cyc, mon_e.press, mon_e.rel, mon_e.rep, mon_e.any}) begin
          n_bad++;
          $display("FAIL mon: got cyc=%0d press=%b rel=%b rep=%b any=%b, want cyc=%0d press=%b rel=%b rep=%b any=%b",
                   cyc, press, rel, rep, anyp, mon_e.cyc, mon_e.press, mon_e.rel, mon_e.rep, mon_e.any);
        end
      end
    end
  end

  // Monitor for the repeat-disabled instance
  always @(negedge clk) begin
    if (nrst && ((|press_nr) || (|rel_nr) || (|rep_nr) || anyp_nr)) begin
      n_cmp++;
      if (exp_nr_q.size() == 0) begin
        n_bad++;
        $display("FAIL mon_nr: unexpected event cyc=%0d press=%b rel=%b rep=%b any=%b, none required",
                 cyc, press_nr, rel_nr, rep_nr, anyp_nr);
      end else begin
        mon_nr_e = exp_nr_q.pop_front();
        if ({cyc, press_nr, rel_nr, rep_nr, anyp_nr} !==
            {mon_nr_e.cyc, mon_nr_e.press, mon_nr_e.rel, mon_nr_e.rep, mon_nr_e.any}) begin
          n_bad++;
          $display("FAIL mon_nr: got cyc=%0d press=%b rel=%b rep=%b any=%b, want cyc=%0d press=%b rel=%b rep=%b any=%b",
                   cyc, press_nr, rel_nr, rep_nr, anyp_nr, mon_nr_e.cyc, mon_nr_e.press,
                   mon_nr_e.rel, mon_nr_e.rep, mon_nr_e.any);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input bit nr, input int c, input logic [5:0] p, input logic [5:0] r,
                         input logic [5:0] rp, input logic a);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = rp; e.any = a;
    if (nr) exp_nr_q.push_back(e);
    else    exp_q.push_back(e);
  endtask

  // Press at p, repeats at p+10, p+13, ... strictly before r, release at r
  task automatic push_hold(input logic [5:0] mask, input int p, input int r, input bit nr);
    push_ev(nr, p, mask, 6'b0, 6'b0, 1'b1);
    if (!nr) begin
      for (int t = p + 10; t < r; t += 3) push_ev(nr, t, 6'b0, 6'b0, mask, 1'b1);
    end
    push_ev(nr, r, 6'b0, mask, 6'b0, 1'b0);
  endtask

  initial begin
    raw = '0; raw_nr = '0; en = 1'b1;
    #1 nrst = 1'b0;
    #1;
    check("reset_outputs", 32'({level, press, rel, rep, anyp}), 32'd0);
    check("reset_outputs_nr", 32'({level_nr, press_nr, rel_nr, rep_nr, anyp_nr}), 32'd0);
    step(3);
    nrst = 1'b1;
    step(3);

    // 1: clean press and release of button 0 (repeats run while held)
    m = cyc;
    push_hold(6'b000001, m + 6, m + 36, 1'b0);
    raw[0] = 1'b1;
    step(5);  check("t1_level_before", 32'(level), 32'h00);
    step(1);  check("t1_level_after",  32'(level), 32'h01);
    step(24); raw[0] = 1'b0;
    step(5);  check("t1_level_hold",   32'(level), 32'h01);
    step(1);  check("t1_level_fall",   32'(level), 32'h00);
    step(5);

    // 2: bounce on button 2 every 3 cycles, then settle high
    m = cyc;
    push_hold(6'b000100, m + 36, m + 48, 1'b0);
    for (int k = 0; k < 10; k++) begin
      raw[2] = (k % 2 == 0);
      step(3);
    end
    raw[2] = 1'b1;
    step(5);  check("t2_level_before", 32'(level), 32'h00);
    step(1);  check("t2_level_after",  32'(level), 32'h04);
    step(6);  raw[2] = 1'b0;
    step(10); check("t2_level_end",    32'(level), 32'h00);

    // 3: hold button 1 for 40 cycles; repeat due on release edge is dropped
    m = cyc;
    push_hold(6'b000010, m + 6, m + 46, 1'b0);
    raw[1] = 1'b1;
    step(40); raw[1] = 1'b0;
    step(10); check("t3_level_end", 32'(level), 32'h00);

    // 4: all six buttons at once
    m = cyc;
    push_hold(6'b111111, m + 6, m + 14, 1'b0);
    raw = 6'h3f;
    step(6);  check("t4_level_all",  32'(level), 32'h3f);
    step(2);  raw = 6'h00;
    step(6);  check("t4_level_none", 32'(level), 32'h00);
    step(4);

    // 5: enable drop/raise while held, then async reset mid-confirm
    m = cyc;
    push_ev(1'b0, m + 6,  6'b001000, 6'b0, 6'b0, 1'b1);
    push_ev(1'b0, m + 16, 6'b0, 6'b0, 6'b001000, 1'b1);
    push_ev(1'b0, m + 19, 6'b0, 6'b0, 6'b001000, 1'b1);
    push_ev(1'b0, m + 29, 6'b001000, 6'b0, 6'b0, 1'b1);
    raw[3] = 1'b1;
    step(20); check("t5_level_held", 32'(level), 32'h08);
    en = 1'b0;
    step(1);  check("t5_en_clear", 32'({level, press, rel, rep, anyp}), 32'd0);
    step(4);  en = 1'b1;
    step(3);  check("t5_requal_before", 32'(level), 32'h00);
    step(1);  check("t5_requal_press",  32'({level, press}), 32'({6'h08, 6'h08}));
    step(1);  raw[3] = 1'b0;
    step(1);  raw[5] = 1'b1;
    step(3);  check("t5_pre_reset", 32'(level), 32'h08);
    nrst = 1'b0;
    #1;
    check("t5_async_reset", 32'({level, press, rel, rep, anyp}), 32'd0);
    raw = '0;
    step(2);  nrst = 1'b1;
    step(12); check("t5_after_reset", 32'(level), 32'h00);

    // 6: repeat disabled, hold for 100 cycles
    m = cyc;
    push_hold(6'b000001, m + 6, m + 106, 1'b1);
    raw_nr[0] = 1'b1;
    step(6);  check("t6_level_nr", 32'(level_nr), 32'h01);
    step(94); raw_nr[0] = 1'b0;
    step(10); check("t6_level_nr_end", 32'(level_nr), 32'h00);

    check("queue_drained",    32'(exp_q.size()),    32'd0);
    check("queue_nr_drained", 32'(exp_nr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t07_button_conditioner.md
# t07_button_conditioner

Input-conditioning stage for the bomb game: takes the six raw, asynchronous, bouncing breakout-board buttons and produces clean debounced levels, single-cycle press/release pulses and hold-to-repeat pulses for `t07_bomb_game`. It sits between the GPIO input pins (`gpio_in[23:18]`) and the game's `button` input, inside `team_07`. Each button is conditioned independently, with its own synchronizer, debounce counter and repeat timer.

## Interface
- `N_BTN`, 6: number of buttons, minimum 1.
- `DB_LIMIT`, 50000: consecutive disagreeing cycles needed to accept a level change. This is 5 ms at 10 MHz. Minimum 1.
- `REPEAT_DELAY`, 5000000: cycles from a press pulse to the first repeat pulse. 0 disables repeat.
- `REPEAT_PERIOD`, 1000000: cycles between repeat pulses. Minimum 1.
- `clk` in 1: system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `en` in 1: block enable. Low acts as a synchronous clear.
- `button_raw` in N_BTN: raw pin levels, active high, asynchronous.
- `button_level` out N_BTN: debounced level.
- `button_press` out N_BTN: one-cycle pulse on a debounced rise.
- `button_release` out N_BTN: one-cycle pulse on a debounced fall.
- `button_repeat` out N_BTN: one-cycle pulse while the button is held, per the repeat schedule.
- `any_press` out 1: OR of `button_press | button_repeat`, registered alongside them.

## Operation
- **Synchronizer:** each bit passes through 2 flip-flops, `sync1` then `sync2`. These flops run regardless of `en`.
- **Debounce counter:**
  - Each button has a counter of width clog2(DB_LIMIT+1).
  - Each cycle with `sync2 != level`, the counter increments.
  - Any cycle with `sync2 == level` clears the counter.
  - When the counter would reach DB_LIMIT, the counter clears, `level` toggles, and the press or release pulse fires in that same cycle.
- **Per-button FSM:** states are IDLE, CONFIRM_PRESS, HELD and CONFIRM_RELEASE.
  - IDLE -> CONFIRM_PRESS when `sync2`=1.
  - CONFIRM_PRESS -> IDLE when `sync2`=0 before the limit is reached (a glitch).
  - CONFIRM_PRESS -> HELD at the limit.
  - HELD -> CONFIRM_RELEASE and back to HELD are symmetric to the press path.
  - `level` is 1 in HELD and CONFIRM_RELEASE.
- **Repeat timer:**
  - Each button has a counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - The timer is loaded on the press pulse.
  - It counts only while `level`=1, including during CONFIRM_RELEASE.
  - Its first expiry is REPEAT_DELAY cycles after the press pulse. Each later expiry follows REPEAT_PERIOD cycles after the previous one.
  - The timer clears when `level` falls.
- **Independence:** buttons are fully independent. Simultaneous presses produce simultaneous pulses, with no arbitration.
- **Enable:** `en`=0 clears every FSM, counter, level and pulse to 0 on the next edge and holds them there. The synchronizers keep sampling.
  - On `en` rising, a button already held is re-qualified from IDLE.
  - That button therefore produces a press pulse DB_LIMIT cycles later.
- **Reset:** asserting `nrst` mid-debounce or mid-repeat clears everything immediately, without waiting for a clock edge. No pulse is emitted on reset release.

## Timing
- **Reset values:** all outputs, synchronizers, counters and FSMs are 0 / IDLE.
- **Outputs:** all outputs are registered. Pulses are exactly 1 cycle wide.
- **Press latency:** if `button_raw` rises and is stable from just before edge k, then `level` and `press` are high after edge k+1+DB_LIMIT. That is DB_LIMIT+2 edges of latency. Release latency is identical.
- **Press pulse:** the pulse coincides with the first cycle of the new `level`.
- **Glitch rejection:** a raw pulse or bounce lasting fewer than DB_LIMIT cycles at `sync2` never changes `level`.
- **Repeat schedule:** with the press pulse at edge P, repeat pulses occur at edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on.
  - No repeat pulse ever coincides with a press pulse.
  - A repeat pulse never occurs on or after the edge where `level` falls.
- **Simultaneous events:** a repeat expiry on the same edge as the release takes effect as the release pulse only. The repeat pulse is suppressed.

## Test plan
All scenarios use `DB_LIMIT`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3 and `N_BTN`=6.
1. **Clean press and release:** raw[0] goes high at edge 0 and low at edge 30.
   - `level[0]` is high after edge 5 and low after edge 35.
   - `press[0]` is high only in cycle 5. `release[0]` is high only in cycle 35.
   - `any_press` is high in cycle 5.
2. **Bounce rejection:** raw[2] toggles every 3 cycles for 30 cycles, then settles high.
   - No pulses occur during the toggling.
   - A single press occurs 6 edges after the settle.
   - The other bits stay 0 throughout.
3. **Auto-repeat:** hold raw[1] for 40 cycles.
   - Press occurs at edge P.
   - Repeat occurs at P+10, P+13, P+16, and so on, until release.
   - There is no repeat after release, and no coincident press and repeat.
4. **Simultaneous buttons:** raw = 6'b111111 at the same edge.
   - All six presses arrive in the same cycle. `any_press`=1 for 1 cycle.
5. **Enable and reset mid-operation:**
   - Drop `en` while button 3 is held and repeating: all outputs are 0 on the next edge.
   - Raise `en` with button 3 still held: a press pulse follows 4 cycles later.
   - Assert `nrst` mid-confirm: outputs are 0 with no clock, and no press follows reset release unless re-qualified.
6. **Repeat disabled:** `REPEAT_DELAY`=0, hold for 100 cycles.
   - Exactly one press and one release occur, with zero repeats.
